// File: rtl/writeback_queue.sv
// writeback_queue: in-order register write FIFO that drains one entry per cycle to the register file write port
// and forwards the youngest pending value of a register to the two operand read paths.
module writeback_queue #(
    parameter int DEPTH = 4,
    parameter int DW    = 8,
    parameter int AW    = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld_valid,
    input  logic [AW-1:0]            ld_addr,
    input  logic [DW-1:0]            ld_data,
    output logic                     ld_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_addr,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    input  logic                     wb_hold,
    output logic                     write_enable,
    output logic [AW-1:0]            write_addr,
    output logic [DW-1:0]            write_data,
    input  logic [AW-1:0]            fwd_addr_a,
    output logic                     fwd_hit_a,
    output logic [DW-1:0]            fwd_data_a,
    input  logic [AW-1:0]            fwd_addr_b,
    output logic                     fwd_hit_b,
    output logic [DW-1:0]            fwd_data_b,
    output logic [3:0]               pending_mask,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [AW-1:0] q_addr [DEPTH];
    logic [DW-1:0] q_data [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr, idx;
    logic          push, pop;

    assign full      = count == CW'(DEPTH);
    assign empty     = count == '0;
    assign ld_ready  = rst_n & ~full;
    assign alu_ready = rst_n & ~full & ~ld_valid;
    assign push      = (ld_valid & ld_ready) | (alu_valid & alu_ready);
    assign pop       = ~empty & ~wb_hold;

    always_ff @(posedge clk)
        if (rst_n && push) begin
            q_addr[wr_ptr] <= ld_valid ? ld_addr : alu_addr;
            q_data[wr_ptr] <= ld_valid ? ld_data : alu_data;
        end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count        <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + PW'(1);
            if (pop) begin
                rd_ptr     <= rd_ptr + PW'(1);
                write_addr <= q_addr[rd_ptr];
                write_data <= q_data[rd_ptr];
            end
            write_enable <= pop;
            count        <= count + CW'(push) - CW'(pop);
        end
    end

    // Scan oldest to newest so later (younger) matches override earlier ones.
    always_comb begin
        idx          = '0;
        fwd_hit_a    = write_enable && write_addr == fwd_addr_a;
        fwd_data_a   = fwd_hit_a ? write_data : '0;
        fwd_hit_b    = write_enable && write_addr == fwd_addr_b;
        fwd_data_b   = fwd_hit_b ? write_data : '0;
        pending_mask = '0;
        if (write_enable)
            pending_mask[write_addr] = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            idx = rd_ptr + PW'(i);
            if (CW'(i) < count) begin
                pending_mask[q_addr[idx]] = 1'b1;
                if (q_addr[idx] == fwd_addr_a) begin
                    fwd_hit_a  = 1'b1;
                    fwd_data_a = q_data[idx];
                end
                if (q_addr[idx] == fwd_addr_b) begin
                    fwd_hit_b  = 1'b1;
                    fwd_data_b = q_data[idx];
                end
            end
        end
    end
endmodule

// File: doc/writeback_queue.md
Name: writeback_queue

Overview:
Producer side of the 4x8 register file write port. It buffers register write requests from the ALU and the load unit in a small in-order FIFO. It drains the FIFO one entry per cycle onto the register file's write_enable/write_addr/write_data. It also forwards the youngest pending value of a register to the two operand read paths, so the decode stage never reads a stale register.

Parameters:
DEPTH, 4, queue entries (power of two, >=2)
DW, 8, data width (matches register width)
AW, 2, register address width (4 registers)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous reset, active-low
ld_valid  input  1  load-unit write request
ld_addr  input  AW  load destination register
ld_data  input  DW  load data
ld_ready  output  1  load request accepted this cycle when ld_valid&ld_ready
alu_valid  input  1  ALU write request
alu_addr  input  AW  ALU destination register
alu_data  input  DW  ALU result
alu_ready  output  1  ALU request accepted when alu_valid&alu_ready
wb_hold  input  1  1 = do not pop a new entry this cycle
write_enable  output  1  to register file write_enable (registered)
write_addr  output  AW  to register file write_addr (registered)
write_data  output  DW  to register file write_data (registered)
fwd_addr_a  input  AW  operand A register address
fwd_hit_a  output  1  A has a pending (queued or in-flight) write
fwd_data_a  output  DW  youngest pending value for A, 0 on miss
fwd_addr_b  input  AW  operand B register address
fwd_hit_b  output  1  as A
fwd_data_b  output  DW  as A
pending_mask  output  4  bit i = register i has a pending write
count  output  $clog2(DEPTH)+1  queued entries, excludes in-flight output
full  output  1  count==DEPTH
empty  output  1  count==0

Behaviour:
- Reset (rst_n==0 at posedge):
  - count, read/write pointers -> 0
  - write_enable, write_addr, write_data -> 0
  - queued entries discarded and never written
  - ld_ready, alu_ready forced 0 while rst_n==0
  - Reset mid-drain: an entry on the outputs during the reset cycle is dropped (write_enable 0 next cycle)
- Enqueue (at most one per cycle):
  - ld_ready = rst_n & !full
  - alu_ready = rst_n & !full & !ld_valid (load has priority)
  - Ready depends only on registered count, not on a same-cycle pop; no valid->ready combinational path beyond the ld_valid priority term
  - Accepted entry written at wr_ptr; wr_ptr increments modulo DEPTH (wrap)
- Drain:
  - At each posedge with rst_n==1, if !empty & !wb_hold: head popped, rd_ptr increments mod DEPTH, write_enable<=1, write_addr/write_data<=head
  - Otherwise write_enable<=0 and write_addr/write_data hold
  - write_enable is high exactly one cycle per entry; back-to-back entries give consecutive high cycles
- Latency: request accepted at edge N -> earliest write_enable high in the cycle after edge N+1 -> register file captures at edge N+2
- Simultaneous push and pop:
  - count unchanged; both pointers advance
  - When full, no push occurs (ready=0) even if a pop occurs that edge
- Ordering: strict FIFO; same-address writes retire in acceptance order
- Forwarding (combinational):
  - Candidates: all queued entries plus the in-flight output entry when write_enable==1
  - Hit selects the youngest matching candidate, age order: newest queued down to oldest queued, then in-flight
  - Miss gives hit=0, data=0
  - Same-cycle incoming requests are not candidates
- pending_mask = OR over candidates of one-hot(addr)
- Width rules: data passes unmodified; no arithmetic on data

Test Plan:
- Reset mid-operation: wb_hold=1, queue R0=1, R1=2, R2=3, then rst_n=0 for 2 cycles -> count=0, empty=1, write_enable=0, pending_mask=0; after release no writes of 1/2/3 appear.
- Latency: ALU R2=0x5A accepted at edge N -> write_enable=1, write_addr=2, write_data=0x5A in cycle after N+1 only; pending_mask=4'b0100 from after N until after N+2.
- Priority: ld R1=0x11 and alu R1=0x22 both valid -> ld_ready=1, alu_ready=0; ALU accepted next cycle; writes retire 0x11 then 0x22; fwd_addr_a=1 returns hit=1, data=0x22 once both are queued.
- Full/wrap: wb_hold=1, push 4 entries (R0..R3 = 0xA0..0xA3) -> full=1, both readys 0, a fifth request is held; drop wb_hold -> 4 consecutive write_enable cycles in order; fifth accepted after the first pop; pointers wrap; count returns to 0.
- Forward miss/hit: queue R3=0x7F, fwd_addr_a=3, fwd_addr_b=0 -> fwd_hit_a=1, fwd_data_a=0x7F, fwd_hit_b=0, fwd_data_b=0; hit persists while 0x7F is in-flight, clears after retire.
- Hold during drain: 2 entries queued, wb_hold rises while the first is on the outputs -> first write_enable cycle completes; write_enable=0 until wb_hold falls; then the second entry is written.
